// File: rtl/ats_pkg.sv
// Shared ATS definitions: the appender and the extractor both size the
// timestamp trailer from this package, so the two ends agree on its length.
package ats_pkg;

   localparam int ATS_TIMESTAMP_WIDTH = 72;

   // Number of beats a trailer occupies on a stream of the given beat width.
   function automatic int ts_beats(input int ts_width, input int data_width);
      return ts_width / data_width;
   endfunction

endpackage

// File: rtl/extract_timestamp.sv
// Strips the timestamp trailer from each frame, restores tlast on the last
// frame beat and delivers the trailer as one parallel word on a side channel.
module extract_timestamp
   import ats_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int TIMESTAMP_WIDTH = ATS_TIMESTAMP_WIDTH
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [TIMESTAMP_WIDTH-1:0] m_ts_tdata,
   output logic                       m_ts_tvalid,
   input  logic                       m_ts_tready,
   output logic                       frame_error
);

   localparam int N     = ts_beats(TIMESTAMP_WIDTH, DATA_WIDTH);
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

   logic [TIMESTAMP_WIDTH-1:0] r_dly;
   logic [CNT_W-1:0]           r_cnt;
   logic [TIMESTAMP_WIDTH-1:0] r_ts_data;
   logic                       r_ts_valid;
   logic                       r_frame_error;

   logic                       w_full;
   logic                       w_slot_ok;
   logic                       w_accept;
   logic [TIMESTAMP_WIDTH-1:0] w_shift;

   // The delay line holds the last N beats; once full, its oldest beat is a
   // frame beat and the incoming beat decides whether that beat was the last.
   assign w_full    = (r_cnt == CNT_FULL);
   assign w_slot_ok = !s_axis_tlast || !r_ts_valid || m_ts_tready;
   assign w_shift   = {s_axis_tdata, r_dly[TIMESTAMP_WIDTH-1:DATA_WIDTH]};

   assign s_axis_tready = w_full ? (m_axis_tready && w_slot_ok) : 1'b1;
   assign m_axis_tvalid = w_full && s_axis_tvalid && w_slot_ok;
   assign m_axis_tdata  = r_dly[DATA_WIDTH-1:0];
   assign m_axis_tlast  = w_full && s_axis_tlast;
   assign w_accept      = s_axis_tvalid && s_axis_tready;

   assign m_ts_tdata  = r_ts_data;
   assign m_ts_tvalid = r_ts_valid;
   assign frame_error = r_frame_error;

   // NOTE: the delay line is reset along with the control state so that a
   // reset leaves no stale frame bytes behind; state updates are all <=.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_dly         <= '0;
         r_cnt         <= '0;
         r_ts_data     <= '0;
         r_ts_valid    <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_frame_error <= 1'b0;

         if (r_ts_valid && m_ts_tready)
            r_ts_valid <= 1'b0;

         if (w_accept) begin
            if (!w_full) begin
               if (s_axis_tlast) begin
                  r_cnt         <= '0;
                  r_frame_error <= 1'b1;
               end else begin
                  r_dly <= w_shift;
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_dly <= w_shift;
               if (s_axis_tlast) begin
                  // A new load overrides the clear above, keeping valid high.
                  r_ts_data  <= w_shift;
                  r_ts_valid <= 1'b1;
                  r_cnt      <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_extract_timestamp.sv
// Directed bench for extract_timestamp: a frame-level vector table plus
// hand-written sequences for timestamp stall, random back-pressure and reset.
module tb_extract_timestamp;

   localparam int DW  = 8;
   localparam int TW  = 72;
   localparam int NB  = TW / DW;
   localparam int BUDGET = 300;

   typedef logic [7:0] bytes_t [$];

   typedef struct {
      int          len;
      logic [7:0]  first;
      logic [7:0]  step;
      logic [71:0] ts;
      int          exp_beats;
      int          exp_ts;
      int          exp_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [TW-1:0] m_ts_tdata;
   logic          m_ts_tvalid;
   logic          m_ts_tready;
   logic          frame_error;

   int total = 0;
   int bad   = 0;

   logic [8:0]  out_q [$];
   logic [71:0] ts_q  [$];
   int          err_cnt;
   logic [8:0]  exp_q  [$];
   logic [71:0] exp_ts [$];
   bit          rand_bp = 1'b0;

   extract_timestamp #(.DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_ts_tdata    (m_ts_tdata),
      .m_ts_tvalid   (m_ts_tvalid),
      .m_ts_tready   (m_ts_tready),
      .frame_error   (frame_error)
   );

   always #5 clk = ~clk;

   // Monitor at negedge: handshakes seen here complete on the next posedge.
   always @(negedge clk) begin
      if (rstn) begin
         if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
         if (m_ts_tvalid && m_ts_tready)     ts_q.push_back(m_ts_tdata);
         if (frame_error)                    err_cnt++;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_bp) m_axis_tready = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (s_axis_tready) break;
         if (t > BUDGET) begin
            check("s_ready_timeout", 128'(s_axis_tready), 128'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Sends data + trailer and records the expected output in the scoreboard.
   task automatic send_frame(input bytes_t d, input logic [71:0] ts);
      for (int i = 0; i < d.size(); i++) exp_q.push_back({i == d.size() - 1, d[i]});
      if (d.size() > 0) exp_ts.push_back(ts);
      for (int i = 0; i < d.size(); i++) send_beat(d[i], 1'b0);
      for (int j = 0; j < NB; j++) send_beat(ts[8*j +: 8], j == NB - 1);
   endtask

   task automatic clear_sb();
      out_q.delete(); ts_q.delete(); exp_q.delete(); exp_ts.delete();
      err_cnt = 0;
   endtask

   task automatic compare_streams(input string tag);
      check({tag, "_beat_count"}, 128'(out_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         check({tag, "_beat"}, 128'(out_q[i]), 128'(exp_q[i]));
      check({tag, "_ts_count"}, 128'(ts_q.size()), 128'(exp_ts.size()));
      for (int i = 0; i < ts_q.size() && i < exp_ts.size(); i++)
         check({tag, "_ts"}, 128'(ts_q[i]), 128'(exp_ts[i]));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t   vecs [5];
      bytes_t d;
      bit     done;
      bit     found;
      int     lasts;

      vecs[0] = '{4,  8'h11, 8'h11, 72'h090807060504030201, 4,  1, 0};
      vecs[1] = '{1,  8'hAA, 8'h00, 72'h123456789ABCDEF012, 1,  1, 0};
      vecs[2] = '{0,  8'h00, 8'h00, 72'hA1A2A3A4A5A6A7A8A9, 0,  0, 1};
      vecs[3] = '{3,  8'hF0, 8'h01, 72'hFEDCBA987654321000, 3,  1, 0};
      vecs[4] = '{10, 8'h30, 8'h03, 72'h5A5A5A5A5A5A5A5A5A, 10, 1, 0};

      rstn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1; m_ts_tready = 1'b1;
      clear_sb();
      idle(3);
      rstn = 1'b1;
      idle(1);

      check("rst_m_tvalid",  128'(m_axis_tvalid), 128'd0);
      check("rst_ts_tvalid", 128'(m_ts_tvalid),   128'd0);
      check("rst_ts_tdata",  128'(m_ts_tdata),    128'd0);
      check("rst_frame_err", 128'(frame_error),   128'd0);
      check("rst_s_tready",  128'(s_axis_tready), 128'd1);

      for (int v = 0; v < 5; v++) begin
         clear_sb();
         d = {};
         for (int i = 0; i < vecs[v].len; i++) d.push_back(8'(vecs[v].first + i * vecs[v].step));
         send_frame(d, vecs[v].ts);
         check("ts_valid_timing", 128'(m_ts_tvalid), 128'(vecs[v].exp_ts));
         check("err_pulse",       128'(frame_error), 128'(vecs[v].exp_err));
         idle(3);
         check("vec_beats", 128'(out_q.size()), 128'(vecs[v].exp_beats));
         check("vec_errs",  128'(err_cnt),      128'(vecs[v].exp_err));
         compare_streams("vec");
      end

      // Timestamp back-pressure: second frame stalls on its tlast beat.
      clear_sb();
      m_ts_tready = 1'b0;
      done = 1'b0;
      fork
         begin
            bytes_t a, b;
            for (int i = 0; i < 5; i++) begin a.push_back(8'(8'h50 + i)); b.push_back(8'(8'h60 + i)); end
            send_frame(a, 72'h111111111111111111);
            send_frame(b, 72'h222222222222222222);
            done = 1'b1;
         end
      join_none
      found = 1'b0;
      for (int t = 0; t < BUDGET && !found; t++) begin
         @(negedge clk);
         if (s_axis_tvalid && s_axis_tlast && !s_axis_tready && out_q.size() >= 5) found = 1'b1;
      end
      check("stall_seen",       128'(found),         128'd1);
      check("stall_m_tvalid",   128'(m_axis_tvalid), 128'd0);
      check("stall_ts_pending", 128'(m_ts_tdata),    128'h111111111111111111);
      idle(4);
      check("stall_hold_beats", 128'(out_q.size()),  128'd9);
      check("stall_hold_ready", 128'(s_axis_tready), 128'd0);
      m_ts_tready = 1'b1;
      for (int t = 0; t < BUDGET && !done; t++) idle(1);
      check("bp_done", 128'(done), 128'd1);
      idle(3);
      compare_streams("tsbp");

      // Random m_axis back-pressure over 64-byte frames.
      clear_sb();
      rand_bp = 1'b1;
      for (int f = 0; f < 3; f++) begin
         d = {};
         for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
         send_frame(d, {8'(f), 64'($urandom) << 32 | 64'($urandom)});
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #2;
      m_axis_tready = 1'b1;
      idle(3);
      lasts = 0;
      foreach (out_q[i]) if (out_q[i][8]) lasts++;
      check("rand_tlast_count", 128'(lasts), 128'd3);
      compare_streams("rand");

      // Reset mid-frame with a timestamp pending.
      clear_sb();
      m_ts_tready = 1'b0;
      d = {8'h01, 8'h02};
      send_frame(d, 72'h333333333333333333);
      for (int i = 0; i < 5; i++) send_beat(8'(8'hC0 + i), 1'b0);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      check("mid_rst_ts_tvalid", 128'(m_ts_tvalid),   128'd0);
      check("mid_rst_ts_tdata",  128'(m_ts_tdata),    128'd0);
      check("mid_rst_m_tvalid",  128'(m_axis_tvalid), 128'd0);
      check("mid_rst_err",       128'(frame_error),   128'd0);
      m_ts_tready = 1'b1;
      clear_sb();
      d = {8'hD1, 8'hD2, 8'hD3};
      send_frame(d, 72'h0F0E0D0C0B0A090807);
      idle(3);
      check("post_rst_errs", 128'(err_cnt), 128'd0);
      compare_streams("postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/extract_timestamp.md
# extract_timestamp

Receive-side counterpart of the ATS timestamp appender. Accepts an AXI4-Stream where each Ethernet frame is followed by a TIMESTAMP_WIDTH-bit timestamp trailer, with tlast only on the final trailer beat. Re-emits the bare frame with tlast restored on its last data beat, and delivers the trailer as one parallel timestamp on a separate AXI4-Stream side channel. It sits in the ATS path downstream of the timestamp insertion and queueing stages, feeding eligibility-time computation.

## Interface
- DATA_WIDTH, 8, beat width in bits.
- TIMESTAMP_WIDTH, 72, trailer width; must be a multiple of DATA_WIDTH.
- Derived: N = TIMESTAMP_WIDTH/DATA_WIDTH (trailer beats); CNT_W = $clog2(N+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  frame beats followed by trailer beats.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  marks the last trailer beat.
- m_axis_tdata  out  DATA_WIDTH  frame beat.
- m_axis_tvalid  out  1  frame valid.
- m_axis_tready  in  1  frame ready.
- m_axis_tlast  out  1  last frame beat.
- m_ts_tdata  out  TIMESTAMP_WIDTH  extracted timestamp.
- m_ts_tvalid  out  1  timestamp valid.
- m_ts_tready  in  1  timestamp ready.
- frame_error  out  1  one-cycle pulse when a malformed frame is discarded.

## Operation
- **Delay line.** A shift register dly[TIMESTAMP_WIDTH-1:0] plus fill counter cnt (0..N) holds the most recent N accepted beats.
  - Each accepted beat does dly <= {s_axis_tdata, dly[TIMESTAMP_WIDTH-1:DATA_WIDTH]}.
  - The oldest beat sits at dly[DATA_WIDTH-1:0]. Trailer beat 0 is the timestamp LSB.
- **FILL state (cnt < N).**
  - s_axis_tready = 1. m_axis_tvalid = 0.
  - A non-last beat is accepted and cnt increments.
- **FILL, tlast accepted.** The frame is malformed (total beats ≤ N, so there is no frame data).
  - Discard everything; cnt <= 0.
  - frame_error pulses next cycle.
  - No timestamp output and no frame output.
- **FULL state (cnt == N).** Pass-through with an N-beat delay.
  - m_axis_tdata = dly[DATA_WIDTH-1:0].
  - m_axis_tvalid = s_axis_tvalid & slot_ok.
  - m_axis_tlast = s_axis_tlast.
  - s_axis_tready = m_axis_tready & slot_ok.
  - slot_ok = !s_axis_tlast | !m_ts_tvalid | m_ts_tready.
  - An input beat is accepted exactly when a frame beat is emitted.
- **FULL, non-last beat accepted.** Shift; cnt stays N.
- **FULL, tlast beat accepted.**
  - m_ts_tdata <= {s_axis_tdata, dly[TIMESTAMP_WIDTH-1:DATA_WIDTH]}; m_ts_tvalid <= 1.
  - cnt <= 0; return to FILL.
- **Timestamp channel.**
  - m_ts_tvalid clears on m_ts_tvalid & m_ts_tready, unless a new timestamp loads in the same cycle, in which case it stays 1 with the new data.
  - m_ts_tdata is stable while valid and not ready.
- **Back-to-back frames.** The next frame's first beat may be accepted the cycle after tlast; cnt restarts at 0.
- **Reset.** All outputs deassert the cycle after rstn is sampled low: m_axis_tvalid=0, m_ts_tvalid=0, frame_error=0, m_ts_tdata=0, cnt=0, dly=0. A partial frame in flight is lost.

## Timing
- Frame beat k appears on m_axis in the same cycle that input beat k+N is accepted (combinational pass-through, zero added cycles).
- m_ts_tvalid rises 1 cycle after the input tlast handshake.
- Combinational paths:
  - s_axis_tready depends on m_axis_tready, m_ts_tready, m_ts_tvalid, s_axis_tlast and cnt.
  - m_axis_tvalid depends on s_axis_tvalid.
  - Downstream must not make m_axis_tready combinationally depend on m_axis_tvalid through a loop back to s_axis_tvalid.
- AXI4-Stream rules hold. m_axis outputs mirror the input, so their stability under back-pressure depends on upstream holding its beat stable, which AXI requires of it.
- **Stall.** A tlast beat while an unconsumed timestamp is pending holds s_axis_tready = 0 and m_axis_tvalid = 0 until m_ts_tready.

## Structure
- TIMESTAMP_WIDTH default and the beat-count derivation go in the shared ATS package (ats_pkg), shared with the appender so both ends agree.
- Single flat module. No sub-module: the delay line doubles as the timestamp assembler.
- Target 120–200 lines.

## Test plan
All cases use DATA_WIDTH=8, TIMESTAMP_WIDTH=72 (N=9).
- **Basic frame.** 4-beat frame 0x11..0x44 + 9-beat trailer 0x01..0x09, tlast on 0x09, all ready high.
  - m_axis: 0x11..0x44 with tlast on 0x44.
  - m_ts_tdata = 0x090807060504030201, valid 1 cycle after input tlast.
- **Timestamp back-pressure.** Two back-to-back frames with m_ts_tready=0.
  - Second frame's data flows until its tlast beat, then s_axis_tready=0.
  - Release m_ts_tready: first timestamp taken, second loaded; no beat lost.
- **Random frame back-pressure.** m_axis_tready toggled randomly over 64-byte frames.
  - Output byte sequence equals input minus trailers.
  - m_axis_tlast count = frame count.
- **Malformed frame.** Input of exactly 9 beats with tlast on the 9th.
  - frame_error pulses once; no m_axis or m_ts activity.
  - Next valid frame is extracted correctly.
- **Minimum frame.** 1 data beat 0xAA + trailer.
  - m_axis emits a single beat 0xAA with tlast=1.
  - Timestamp is correct.
- **Reset mid-frame.** rstn low for 1 cycle after 5 beats.
  - All valids are 0 the next cycle.
  - A following clean frame is extracted with the correct data and timestamp.
